// File: rtl/uart_loader.sv
// UART-driven memory loader: parses W/R packets from the receive FIFO, issues
// word writes/reads on a simple request/ready port and streams read data + ACK back.
module uart_loader #(
    parameter int         ADDR_WIDTH = 16,
    parameter int         TIMEOUT    = 1000000,
    parameter logic [7:0] ACK_BYTE   = 8'h4B
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [7:0]            recv_data,
    input  logic                  receivable,
    output logic                  recv_flag,
    input  logic                  sendable,
    output logic                  send_flag,
    output logic [7:0]            send_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic                  mem_ready,
    input  logic [31:0]           mem_rdata,
    output logic                  busy,
    output logic                  err_cmd,
    output logic                  err_timeout
);
    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_WBYTE, S_WMEM, S_RREQ, S_RWAIT, S_RSEND, S_ACK
    } state_t;

    state_t                r_state, w_next;
    logic [1:0]            r_hdr_cnt, r_byte_cnt;
    logic                  r_is_wr;
    logic [23:0]           r_hdr;
    logic [15:0]           r_len;
    logic [31:0]           r_wdata, r_rdata;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [TW-1:0]         r_tmo;
    logic                  r_err_cmd, r_err_tmo;
    logic                  w_pop, w_push, w_cmd_ok, w_tmo_hit, w_rx_state;

    assign w_cmd_ok   = (recv_data == 8'h57) || (recv_data == 8'h52);
    assign w_rx_state = (r_state == S_HDR) || (r_state == S_WBYTE);
    assign w_tmo_hit  = w_rx_state && !receivable && (r_tmo == TMO_LAST);

    // recv_flag is combinational so the popped byte is the same-cycle head;
    // gating with RST_N keeps it low while reset is held.
    assign recv_flag   = w_pop & RST_N;
    assign send_flag   = w_push;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign busy        = (r_state != S_IDLE);
    assign err_cmd     = r_err_cmd;
    assign err_timeout = r_err_tmo;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_push    = 1'b0;
        send_data = 8'h00;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_pop = receivable;
                if (w_pop && w_cmd_ok) w_next = S_HDR;
            end
            S_HDR: begin
                w_pop = receivable;
                if (w_pop && r_hdr_cnt == 2'd3) begin
                    if ({recv_data, r_hdr[23:16]} == 16'd0) w_next = S_ACK;
                    else                                   w_next = r_is_wr ? S_WBYTE : S_RREQ;
                end else if (w_tmo_hit) w_next = S_IDLE;
            end
            S_WBYTE: begin
                w_pop = receivable;
                if (w_pop && r_byte_cnt == 2'd3) w_next = S_WMEM;
                else if (w_tmo_hit)              w_next = S_IDLE;
            end
            S_WMEM: begin
                mem_we = 1'b1;
                if (mem_ready) w_next = (r_len == 16'd1) ? S_ACK : S_WBYTE;
            end
            S_RREQ: begin
                mem_re = 1'b1;
                if (mem_ready) w_next = S_RWAIT;
            end
            S_RWAIT: w_next = S_RSEND;
            S_RSEND: begin
                send_data = r_rdata[{r_byte_cnt, 3'b000} +: 8];
                w_push    = sendable;
                if (w_push && r_byte_cnt == 2'd3) w_next = (r_len == 16'd1) ? S_ACK : S_RREQ;
            end
            S_ACK: begin
                send_data = ACK_BYTE;
                w_push    = sendable;
                if (w_push) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_hdr_cnt  <= '0;
            r_byte_cnt <= '0;
            r_is_wr    <= 1'b0;
            r_hdr      <= '0;
            r_len      <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_addr     <= '0;
            r_tmo      <= '0;
            r_err_cmd  <= 1'b0;
            r_err_tmo  <= 1'b0;
        end else begin
            r_err_cmd <= (r_state == S_IDLE) && w_pop && !w_cmd_ok;
            r_err_tmo <= w_tmo_hit;
            // Only idle cycles while waiting on the receiver count; stalls elsewhere never do.
            if (w_pop || !w_rx_state) r_tmo <= '0;
            else                      r_tmo <= r_tmo + 1'b1;
            case (r_state)
                S_IDLE: if (w_pop && w_cmd_ok) begin
                    r_is_wr   <= (recv_data == 8'h57);
                    r_hdr_cnt <= 2'd0;
                end
                S_HDR: if (w_pop) begin
                    r_hdr_cnt <= r_hdr_cnt + 1'b1;
                    case (r_hdr_cnt)
                        2'd0: r_hdr[7:0]   <= recv_data;
                        2'd1: r_hdr[15:8]  <= recv_data;
                        2'd2: r_hdr[23:16] <= recv_data;
                        default: begin
                            r_addr     <= ADDR_WIDTH'(r_hdr[15:0]);
                            r_len      <= {recv_data, r_hdr[23:16]};
                            r_byte_cnt <= 2'd0;
                        end
                    endcase
                end
                S_WBYTE: if (w_pop) begin
                    r_wdata[{r_byte_cnt, 3'b000} +: 8] <= recv_data;
                    r_byte_cnt <= r_byte_cnt + 1'b1;
                end
                S_WMEM: if (mem_ready) begin
                    r_addr     <= r_addr + 1'b1;
                    r_len      <= r_len - 1'b1;
                    r_byte_cnt <= 2'd0;
                end
                S_RWAIT: begin
                    r_rdata    <= mem_rdata;
                    r_byte_cnt <= 2'd0;
                end
                S_RSEND: if (w_push) begin
                    r_byte_cnt <= r_byte_cnt + 1'b1;
                    if (r_byte_cnt == 2'd3) begin
                        r_addr <= r_addr + 1'b1;
                        r_len  <= r_len - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/uart_loader.md
UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, memory word-address width; the header address is 16 bits, zero-extended or truncated to ADDR_WIDTH.
REQ-002 Parameter TIMEOUT, default 1000000, idle clock cycles allowed between received bytes inside a packet.
REQ-003 Parameter ACK_BYTE, default 8'h4B, completion byte sent after every accepted packet.
REQ-004 CLK  input  1  single clock; all logic on posedge.
REQ-005 RST_N  input  1  reset, asynchronous, active-low.
REQ-006 recv_data, receivable  input  8, 1  head of the UART receive FIFO; head byte valid while receivable=1.
REQ-007 recv_flag  output  1  one-cycle pop of the receive FIFO head.
REQ-008 sendable  input  1  UART send FIFO not full.
REQ-009 send_flag, send_data  output  1, 8  one-cycle push of send_data into the UART send FIFO.
REQ-010 mem_addr, mem_wdata  output  ADDR_WIDTH, 32  word address, write data.
REQ-011 mem_we, mem_re  output  1, 1  write/read request, held until accepted.
REQ-012 mem_ready  input  1  request accepted in any cycle where mem_we|mem_re=1 and mem_ready=1.
REQ-013 mem_rdata  input  32  read data, valid the cycle after read acceptance.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 err_cmd, err_timeout  output  1, 1  one-cycle error pulses.

Function
REQ-016 Packet format: CMD, ADDR[7:0], ADDR[15:8], LEN[7:0], LEN[15:8], then payload; LEN is a 16-bit word count; multi-byte fields little-endian.
REQ-017 CMD 8'h57 = write (4*LEN payload bytes, LE per word); CMD 8'h52 = read (no payload).
REQ-018 States: IDLE, HDR, WBYTE, WMEM, RREQ, RWAIT, RSEND, ACK.
REQ-019 recv_flag SHALL assert only when receivable=1 and the state needs a byte (IDLE, HDR, WBYTE); at most one pop per cycle; the popped byte is recv_data in that same cycle.
REQ-020 send_flag SHALL assert only when sendable=1; at most one push per cycle; a stalled byte is retried unchanged.
REQ-021 IDLE: pop byte; 'W' or 'R' -> HDR with header counter 0; any other byte discarded, err_cmd pulses, stay IDLE.
REQ-022 HDR: pop 4 bytes; after LEN[15:8]: LEN=0 -> ACK; write -> WBYTE; read -> RREQ.
REQ-023 WBYTE: assemble 4 bytes into mem_wdata (first byte to [7:0]); after the 4th -> WMEM.
REQ-024 WMEM: mem_we=1 until mem_ready; on acceptance mem_addr increments, word count decrements; count reaches 0 -> ACK, else -> WBYTE.
REQ-025 RREQ: mem_re=1 until mem_ready, then RWAIT; RWAIT latches mem_rdata on the next cycle -> RSEND.
REQ-026 RSEND: push the 4 latched bytes, [7:0] first; then increment address, decrement count; count 0 -> ACK, else -> RREQ.
REQ-027 ACK: push ACK_BYTE once, then -> IDLE.
REQ-028 Address arithmetic SHALL be modulo 2^ADDR_WIDTH; 16'hFFFF + 1 wraps to 0.
REQ-029 mem_we and mem_re SHALL never be high together; mem_addr and mem_wdata are stable while a request is held.
REQ-030 Timeout counter: cleared on each pop; counts in HDR and WBYTE only; at TIMEOUT -> IDLE, err_timeout pulses, no ACK; a partially assembled word is dropped; words already written remain.
REQ-031 Memory and send-side stalls SHALL never trigger a timeout.

Reset
REQ-032 RST_N=0, including mid-packet, SHALL force IDLE immediately and clear the counters; all outputs go to 0: recv_flag, send_flag, send_data, mem_addr, mem_wdata, mem_we, mem_re, busy, err_cmd, err_timeout.
REQ-033 The first byte popped after reset release is treated as CMD.

Verification
REQ-034 Write: RX 57 10 00 02 00 then 11 22 33 44 AA BB CC DD with mem_ready=1 -> writes 0x44332211 at 0x0010 and 0xDDCCBBAA at 0x0011, then TX 4B.
REQ-035 Read: RX 52 FF FF 02 00, memory[FFFF]=0x01020304, memory[0]=0x05060708 -> TX 04 03 02 01 08 07 06 05 4B; address wraps.
REQ-036 Back-pressure: run the read scenario with sendable toggling every cycle and mem_ready low for 5 cycles -> identical TX stream; no push while sendable=0; no error pulses.
REQ-037 Bad command and LEN=0: RX 00 then 57 00 00 00 00 -> err_cmd pulses once, no memory access, TX 4B.
REQ-038 Timeout: TIMEOUT=100; RX 57 00 00 01 00 11 22, then silence -> err_timeout after 100 cycles, no mem_we, no TX; next packet works.
REQ-039 Reset mid-operation: assert RST_N=0 during WBYTE -> all outputs 0, busy 0; after release a complete read packet succeeds.
